// File: rtl/serial_receiver.sv
`default_nettype none
// ============================================================================
// serial_receiver
// Reassembles MSB-first SIZE-bit chunks into a DinLENGTH-bit word, with
// done pulse, busy and sticky overrun status.
// Revision: 1.0
// ============================================================================
module serial_receiver #(
    parameter int DinLENGTH = 32,
    parameter int SIZE      = 4
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [SIZE-1:0]      DataIn,
    input  logic                 DataValid,
    input  logic                 StartRx,
    input  logic                 Abort,
    output logic                 RxBusy,
    output logic                 RxDone,
    output logic                 Overrun,
    output logic [DinLENGTH-1:0] DataOut
);

    localparam int NCHUNK = DinLENGTH / SIZE;
    localparam int CW     = $clog2(NCHUNK) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [CW-1:0]          count;
    logic [CW-1:0]          count_next;
    logic [DinLENGTH-1:0]   shift;
    logic [DinLENGTH-1:0]   shift_next;
    logic [DinLENGTH-1:0]   shifted;
    logic [DinLENGTH-1:0]   data_out_next;
    logic                   overrun_next;
    logic                   last_chunk;
    logic                   can_start;

    // Truncating the concatenation drops the oldest chunk off the top.
    assign shifted    = DinLENGTH'({shift, DataIn});
    assign last_chunk = (count == CW'(NCHUNK - 1));
    assign can_start  = (state != RECV);

    always_comb begin
        state_next    = state;
        count_next    = count;
        shift_next    = shift;
        data_out_next = DataOut;
        overrun_next  = Overrun;

        case (state)
            IDLE, DONE: begin
                if (StartRx) begin
                    state_next = RECV;
                    count_next = '0;
                    shift_next = '0;
                end else begin
                    state_next = IDLE;
                end
            end
            RECV: begin
                if (Abort) begin
                    state_next = IDLE;
                end else if (DataValid) begin
                    shift_next = shifted;
                    count_next = count + CW'(1);
                    if (last_chunk) begin
                        state_next    = DONE;
                        data_out_next = shifted;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // A dropped chunk outranks the clear from a simultaneous StartRx.
        if (can_start && DataValid) begin
            overrun_next = 1'b1;
        end else if (can_start && StartRx) begin
            overrun_next = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= IDLE;
            count   <= '0;
            shift   <= '0;
            DataOut <= '0;
            Overrun <= 1'b0;
        end else begin
            state   <= state_next;
            count   <= count_next;
            shift   <= shift_next;
            DataOut <= data_out_next;
            Overrun <= overrun_next;
        end
    end

    assign RxBusy = (state == RECV);
    assign RxDone = (state == DONE);

endmodule
`default_nettype wire
